spi_sck_gen: RTL
================

Name: spi_sck_gen

Overview:
Programmable SPI serial-clock generator. It divides clk_in by a runtime divisor, including odd ratios, with glitch-free divisor changes and selectable idle polarity (CPOL). It produces edge strobes that the shift logic uses to sample and drive data. It supports fixed-length bursts of N clock periods, or free-running operation, and sits between the APB register block and the SPI shift engine.

Parameters:
DIV_W, 8, width of divisor input; max SCK period 2^DIV_W-1 clk_in cycles
LEN_W, 6, width of burst-length input; max burst 2^LEN_W-1 SCK periods

Ports:
clk_in  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-low reset
en  input  1  level: run request; sampled every cycle
cpol  input  1  SCK idle level; sampled only in IDLE
div  input  DIV_W  SCK period N in clk_in cycles; values 0 and 1 are treated as 2
len  input  LEN_W  burst length in SCK periods; 0 = free-run while en=1
sck_out  output  1  registered serial clock
lead_stb  output  1  1-cycle pulse, same cycle sck_out goes idle->active
trail_stb  output  1  1-cycle pulse, same cycle sck_out goes active->idle
done  output  1  1-cycle pulse on the final trailing edge of a completed burst
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, cnt=0, period_cnt=0, sck_out=0, lead_stb=trail_stb=done=0, busy=0. Reset overrides everything, including mid-period; no trailing edge is generated.
- States: IDLE, RUN, STOP.
- IDLE: sck_out<=cpol every cycle. If en=1, latch N=max(div,2), L=N-floor(N/2), H=floor(N/2), LEN=len, cnt<=0, period_cnt<=0, and go to RUN next cycle.
- RUN and STOP counting: cnt increments each cycle.
  - When cnt==L-1: sck_out<=!cpol_latched and lead_stb<=1.
  - When cnt==N-1: sck_out<=cpol_latched, trail_stb<=1, cnt<=0, period_cnt++.
  - Idle phase lasts L cycles and active phase lasts H cycles. Odd N therefore gives an idle phase one cycle longer than the active phase.
- Divisor update: div is re-latched only at the period boundary (the cnt==N-1 cycle) for the next period. A mid-period change never shortens or stretches the current period.
- cpol is latched only at start; cpol changes during RUN/STOP are ignored.
- Burst end: if LEN!=0 and the trailing edge completes period LEN, assert done in the same cycle as trail_stb and go to IDLE. If en is still 1, the next burst starts from IDLE one cycle later (re-latch all inputs).
- en drops in RUN: go to STOP. The current period completes with its trailing edge, then IDLE. No done pulse. If en=0 on the boundary cycle itself, go directly to IDLE.
- en rising again in STOP is ignored until IDLE is reached.
- Free-run (LEN=0): period_cnt wraps modulo 2^LEN_W and is unused for termination.
- busy=1 from the cycle after en is accepted until the cycle after the final trailing edge.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-run: en=1, div=4, period in progress, then rst=0 for 1 cycle -> next cycle sck_out=0, busy=0, all strobes 0, no trail_stb.
- Mode 0, even divisor: cpol=0, div=4, len=3, en accepted at edge k -> sck_out rises at k+3, k+7, k+11 and falls at k+5, k+9, k+13; 3 lead_stb, 3 trail_stb, done at k+13 only; busy falls at k+14.
- Odd ratio and mode 3: cpol=1, div=5, len=2 -> each period is 3 cycles high (idle) then 2 cycles low; period is 5 cycles; 2 lead_stb, 2 trail_stb, done with the second trail_stb; sck_out ends at 1.
- Clamp and free-run: div=0, len=0, en held 20 cycles -> sck_out toggles every cycle (period 2); en dropped mid-active-phase -> exactly one further trail_stb, then IDLE, no done.
- Glitch-free divisor change: div changed 4->8 two cycles into a period -> current period is exactly 4 cycles, following periods are 8 cycles (4 idle, 4 active).
- Back-to-back bursts: len=1, div=2, en held high -> done, then 1 IDLE cycle, then a new burst; cpol toggled during RUN -> takes effect only after IDLE.

Source files
------------

// File: rtl/spi_sck_gen.sv
// Programmable SPI serial-clock generator: runtime divisor (odd ratios allowed),
// CPOL select, lead/trail strobes, fixed-length bursts or free-run.
module spi_sck_gen #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 6
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] len,
  output logic             sck_out,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] n_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] lead_pt;
  logic [DIV_W-1:0] last_pt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] period_cnt;
  logic             cpol_q;

  // Idle phase is the ceiling half of the period, so odd N idles one cycle longer.
  always_comb begin
    div_eff = (div < DIV_W'(2)) ? DIV_W'(2) : div;
    lead_pt = n_q - (n_q >> 1) - DIV_W'(1);
    last_pt = n_q - DIV_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state      <= IDLE;
      n_q        <= DIV_W'(2);
      cnt        <= '0;
      len_q      <= '0;
      period_cnt <= '0;
      cpol_q     <= 1'b0;
      sck_out    <= 1'b0;
      lead_stb   <= 1'b0;
      trail_stb  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lead_stb  <= 1'b0;
      trail_stb <= 1'b0;
      done      <= 1'b0;
      // Stays high through the cycle that shows the final trailing edge.
      busy      <= (state != IDLE) || en;
      case (state)
        IDLE: begin
          sck_out <= cpol;
          if (en) begin
            n_q        <= div_eff;
            cpol_q     <= cpol;
            len_q      <= len;
            cnt        <= '0;
            period_cnt <= '0;
            state      <= RUN;
          end
        end
        RUN, STOP: begin
          if (cnt == lead_pt) begin
            sck_out  <= ~cpol_q;
            lead_stb <= 1'b1;
          end
          if (cnt == last_pt) begin
            sck_out    <= cpol_q;
            trail_stb  <= 1'b1;
            cnt        <= '0;
            period_cnt <= period_cnt + LEN_W'(1);
            n_q        <= div_eff;
            if (state == STOP || !en) begin
              state <= IDLE;
            end else if (len_q != '0 && (period_cnt + LEN_W'(1)) == len_q) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
            if (state == RUN && !en) state <= STOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
